flush_sequencer: RTL

- Parametrised successor of the pipeline flush controller.
- Generates the same combinational pipeline flush/set-PC strobes from commit/CSR/branch events.
- Adds a sequential multi-channel cache flush engine for FENCE/FENCE.I: per-channel req/ack handshake, per-instruction channel masks, core halt while active, and a watchdog timeout. Sits beside commit stage and CSR file; drives frontend, ID, issue, EX, TLBs and NrCaches caches.

---
 rtl/flush_sequencer_pkg.sv | 25 ++
 rtl/flush_sequencer_if.sv | 24 ++
 rtl/flush_watchdog.sv | 51 +++++
 rtl/flush_sequencer.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/flush_sequencer_pkg.sv
// Shared types and defaults for the flush sequencer and its watchdog.
//   flush_fsm_e     : cache flush sequence states
//   Def*            : default channel count, FENCE / FENCE.I masks, watchdog limit
//   cnt_width()     : counter width able to hold 0..limit (minimum 1 bit)
package flush_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } flush_fsm_e;

  localparam int unsigned DefNrCaches      = 2;
  localparam logic [1:0]  DefFenceMask     = 2'b01;
  localparam logic [1:0]  DefFenceIMask    = 2'b11;
  localparam int unsigned DefTimeoutCycles = 4096;

  // A disabled watchdog (limit 0) still needs a legal 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned limit);
    if (limit < 1) return 1;
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/flush_sequencer_if.sv
// Cache flush channel bundle between the flush sequencer and the caches.
//   cache_flush_req_o : per-channel flush request (sequencer -> cache)
//   cache_flush_ack_i : per-channel completion pulse/level (cache -> sequencer)
// Modports: master = sequencer side, slave = cache side.
interface flush_sequencer_if
  import flush_sequencer_pkg::*;
#(
  parameter int unsigned NrCaches = DefNrCaches
) ();

  logic [NrCaches-1:0] cache_flush_req_o;
  logic [NrCaches-1:0] cache_flush_ack_i;

  modport master (
    output cache_flush_req_o,
    input  cache_flush_ack_i
  );

  modport slave (
    input  cache_flush_req_o,
    output cache_flush_ack_i
  );

endinterface

// File: rtl/flush_watchdog.sv
// Saturating cycle watchdog.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   en_i          : count this cycle
//   clr_i         : restart count at zero (wins over en_i)
//   expire_o      : high in an enabled cycle whose count has reached Limit-1
// Limit = 0 disables expiry entirely.
module flush_watchdog
  import flush_sequencer_pkg::*;
#(
  parameter int unsigned Limit = DefTimeoutCycles
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);

  localparam int unsigned    CntW   = cnt_width(Limit);
  localparam logic [CntW-1:0] CntMax = CntW'(Limit);

  logic [CntW-1:0] cnt_d, cnt_q;

  // Saturate at Limit rather than wrapping, so a stuck enable can never
  // roll the counter back under the expiry threshold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  generate
    if (Limit == 0) begin : g_disabled
      assign expire_o = 1'b0;
    end else begin : g_enabled
      assign expire_o = en_i && (cnt_q == CntW'(Limit - 1));
    end
  endgenerate

endmodule

// File: rtl/flush_sequencer.sv
// Pipeline flush controller with a sequential multi-channel cache flush engine.
//   Pipeline strobes (combinational, same cycle as the event):
//     set_pc_commit_o, flush_if_o, flush_unissued_instr_o, flush_id_o,
//     flush_ex_o, flush_bp_o, flush_icache_o, flush_tlb_o
//   Cache flush engine (FENCE / FENCE.I):
//     cache_if  : per-channel req/ack bundle (master modport)
//     halt_o    : halt commit (WFI request or sequence active)
//     busy_o    : sequence active
//     done_o    : one-cycle pulse when a sequence completes
//     timeout_o : sticky watchdog error, cleared only by reset
//   clk_i, rst_ni : clock, asynchronous active-low reset
module flush_sequencer
  import flush_sequencer_pkg::*;
#(
  parameter int unsigned         NrCaches      = DefNrCaches,
  parameter logic [NrCaches-1:0] FenceMask     = NrCaches'(DefFenceMask),
  parameter logic [NrCaches-1:0] FenceIMask    = NrCaches'(DefFenceIMask),
  parameter int unsigned         TimeoutCycles = DefTimeoutCycles
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               mispredict_i,
  input  logic               halt_csr_i,
  input  logic               eret_i,
  input  logic               ex_valid_i,
  input  logic               set_debug_pc_i,
  input  logic               flush_csr_i,
  input  logic               flush_commit_i,
  input  logic               fence_i,
  input  logic               fence_i_i,
  input  logic               sfence_vma_i,
  output logic               set_pc_commit_o,
  output logic               flush_if_o,
  output logic               flush_unissued_instr_o,
  output logic               flush_id_o,
  output logic               flush_ex_o,
  output logic               flush_bp_o,
  output logic               flush_icache_o,
  output logic               flush_tlb_o,
  flush_sequencer_if.master  cache_if,
  output logic               halt_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               timeout_o
);

  flush_fsm_e          state_d, state_q;
  logic [NrCaches-1:0] pending_d, pending_q;
  logic [NrCaches-1:0] req_d, req_q;
  logic [NrCaches-1:0] start_mask;
  logic                timeout_d, timeout_q;
  logic                wd_en, wd_clr, wd_expire;

  // Pipeline flush strobes. Exceptions, eret and debug entry are applied
  // last so they override the commit-PC redirect of a concurrent flush.
  always_comb begin
    set_pc_commit_o        = 1'b0;
    flush_if_o             = 1'b0;
    flush_unissued_instr_o = 1'b0;
    flush_id_o             = 1'b0;
    flush_ex_o             = 1'b0;
    flush_bp_o             = 1'b0;
    flush_icache_o         = 1'b0;
    flush_tlb_o            = 1'b0;

    if (mispredict_i) begin
      flush_if_o             = 1'b1;
      flush_unissued_instr_o = 1'b1;
    end

    if (fence_i || fence_i_i || sfence_vma_i || flush_csr_i || flush_commit_i) begin
      set_pc_commit_o        = 1'b1;
      flush_if_o             = 1'b1;
      flush_unissued_instr_o = 1'b1;
      flush_id_o             = 1'b1;
      flush_ex_o             = 1'b1;
    end

    if (fence_i_i)    flush_icache_o = 1'b1;
    if (sfence_vma_i) flush_tlb_o    = 1'b1;

    if (ex_valid_i || eret_i || set_debug_pc_i) begin
      set_pc_commit_o        = 1'b0;
      flush_if_o             = 1'b1;
      flush_unissued_instr_o = 1'b1;
      flush_id_o             = 1'b1;
      flush_ex_o             = 1'b1;
      flush_bp_o             = 1'b1;
    end
  end

  // Channels selected by the fence instruction(s) of this cycle.
  always_comb begin
    start_mask = '0;
    if (fence_i)   start_mask = start_mask | FenceMask;
    if (fence_i_i) start_mask = start_mask | FenceIMask;
  end

  // Cache flush FSM: next state and register updates. Fences that arrive
  // outside IDLE are not accepted here; commit is halted while busy.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    req_d     = req_q;
    timeout_d = timeout_q;
    wd_en     = 1'b0;
    wd_clr    = 1'b0;

    unique case (state_q)
      IDLE: begin
        req_d     = '0;
        pending_d = start_mask;
        if (|start_mask) state_d = REQ;
      end
      REQ: begin
        req_d   = pending_q;
        wd_clr  = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        wd_en     = 1'b1;
        // Acks on channels that are no longer pending fall out of the AND.
        pending_d = pending_q & ~cache_if.cache_flush_ack_i;
        if (pending_d == '0) begin
          state_d = DONE;
        end else if (wd_expire) begin
          timeout_d = 1'b1;
          pending_d = '0;
          state_d   = DONE;
        end
        req_d = pending_d;
      end
      DONE: begin
        req_d   = '0;
        state_d = IDLE;
      end
      default: begin
        req_d     = '0;
        pending_d = '0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      pending_q <= '0;
      req_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      req_q     <= req_d;
      timeout_q <= timeout_d;
    end
  end

  flush_watchdog #(
    .Limit (TimeoutCycles)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (wd_en),
    .clr_i    (wd_clr),
    .expire_o (wd_expire)
  );

  assign cache_if.cache_flush_req_o = req_q;
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  // Halt is derived from registered state only; no path from the fence inputs.
  assign halt_o    = halt_csr_i | busy_o;
  assign timeout_o = timeout_q;

`ifndef SYNTHESIS
  fence_while_busy_a: assert property (
    @(posedge clk_i) disable iff (!rst_ni) busy_o |-> !(fence_i || fence_i_i)
  ) else $error("fence committed while cache flush sequence active");
`endif

endmodule
